full_adder_4: RTL and testbench

- Registered ripple-carry adder: A + B + c_in -> sum, c_out; default width 4 bits.
- Datapath is a chain of WIDTH one-bit full-adder cells (s = a^b^c, co = ab | c(a^b)).
- Result is captured in an output register; used as an arithmetic leaf wherever a clocked small adder with carry in/out is needed.

---
 rtl/full_adder_4_if.sv | 44 ++++
 rtl/full_adder_4.sv | 115 +++++++++++
 tb/tb_full_adder_4.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/full_adder_4_if.sv
// ----------------------------------------------------------------------------
// full_adder_4_if
// Operand/result bundle for the registered ripple-carry adder.
//   in_valid, A, B, c_in : operand side, driven by the producer (master)
//   sum, c_out, out_valid: registered result side, driven by the adder (slave)
//   ovf, zero            : status flags, present only when the macro
//                          FULL_ADDER4_STATUS_EN is defined
// Parameter WIDTH must match the WIDTH of the full_adder_4 it is bound to.
// ----------------------------------------------------------------------------
interface full_adder_4_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             c_in;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             out_valid;
`ifdef FULL_ADDER4_STATUS_EN
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, A, B, c_in,
        input  sum, c_out, out_valid, ovf, zero
    );

    modport slave (
        input  in_valid, A, B, c_in,
        output sum, c_out, out_valid, ovf, zero
    );
`else
    modport master (
        output in_valid, A, B, c_in,
        input  sum, c_out, out_valid
    );

    modport slave (
        input  in_valid, A, B, c_in,
        output sum, c_out, out_valid
    );
`endif
endinterface

// File: rtl/full_adder_4.sv
// ----------------------------------------------------------------------------
// full_adder_4
// Registered ripple-carry adder: {c_out, sum} = A + B + c_in, one cycle of
// latency, one new operand set accepted per cycle, no backpressure.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset; clears every output register
//   bus  : full_adder_4_if.slave
//          in_valid/A/B/c_in in, sum/c_out/out_valid out
//          ovf/zero out (only with FULL_ADDER4_STATUS_EN)
//
// Optional feature macro: FULL_ADDER4_STATUS_EN
//   When defined, registered signed-overflow (ovf) and sum==0 (zero) flags
//   are produced alongside sum with the same reset and hold behaviour.
//
// Parameter WIDTH: operand/sum width in bits, legal range 1..32.
// ----------------------------------------------------------------------------
module full_adder_4 #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    full_adder_4_if.slave bus
);

    // One full-adder cell: returns {carry_out, sum_bit}.
    function automatic logic [1:0] fa_cell(
        input logic a,
        input logic b,
        input logic c
    );
        fa_cell = {(a & b) | (c & (a ^ b)), a ^ b ^ c};
    endfunction

    logic [WIDTH:0]   carry_s;
    logic [WIDTH-1:0] s_s;

    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             c_out_d;
    logic             c_out_q;
    logic             out_valid_d;
    logic             out_valid_q;
`ifdef FULL_ADDER4_STATUS_EN
    logic             ovf_d;
    logic             ovf_q;
    logic             zero_d;
    logic             zero_q;
`endif

    // Ripple-carry chain: carry_s[0] is c_in, carry_s[WIDTH] is the carry out.
    always_comb begin
        carry_s    = {(WIDTH + 1){1'b0}};
        s_s        = {WIDTH{1'b0}};
        carry_s[0] = bus.c_in;
        for (int i = 0; i < WIDTH; i++) begin
            {carry_s[i+1], s_s[i]} = fa_cell(bus.A[i], bus.B[i], carry_s[i]);
        end
    end

    // Next-state: load a new result on in_valid, otherwise hold the old one.
    // out_valid follows in_valid alone so operand X never reaches it.
    always_comb begin
        sum_d       = sum_q;
        c_out_d     = c_out_q;
        out_valid_d = 1'b0;
`ifdef FULL_ADDER4_STATUS_EN
        ovf_d       = ovf_q;
        zero_d      = zero_q;
`endif
        if (bus.in_valid) begin
            sum_d       = s_s;
            c_out_d     = carry_s[WIDTH];
            out_valid_d = 1'b1;
`ifdef FULL_ADDER4_STATUS_EN
            // Signed overflow: carry into the MSB differs from carry out of it.
            ovf_d       = carry_s[WIDTH] ^ carry_s[WIDTH-1];
            zero_d      = (s_s == {WIDTH{1'b0}});
`endif
        end else begin
            out_valid_d = 1'b0;
        end
    end

    // Output registers with asynchronous active-high clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q       <= {WIDTH{1'b0}};
            c_out_q     <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef FULL_ADDER4_STATUS_EN
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
`endif
        end else begin
            sum_q       <= sum_d;
            c_out_q     <= c_out_d;
            out_valid_q <= out_valid_d;
`ifdef FULL_ADDER4_STATUS_EN
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
`endif
        end
    end

    assign bus.sum       = sum_q;
    assign bus.c_out     = c_out_q;
    assign bus.out_valid = out_valid_q;
`ifdef FULL_ADDER4_STATUS_EN
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
`endif

endmodule

// File: tb/tb_full_adder_4.sv
// ----------------------------------------------------------------------------
// tb_full_adder_4
// Self-checking bench for full_adder_4 at WIDTH = 4, 1 and 16.
// Directed table of vectors and hand sequences on the 4-bit instance, then
// randomized back-to-back traffic on all three instances against an
// arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_full_adder_4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    full_adder_4_if #(.WIDTH(4))  bus4 ();
    full_adder_4_if #(.WIDTH(1))  bus1 ();
    full_adder_4_if #(.WIDTH(16)) bus16 ();

    full_adder_4 #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));
    full_adder_4 #(.WIDTH(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1));
    full_adder_4 #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] exp_sum;
        logic       exp_cout;
        logic       exp_ovf;
        logic       exp_zero;
    } vec_t;

    vec_t vecs [7];

    int widths [3] = '{4, 1, 16};

    logic [31:0] a_r   [3];
    logic [31:0] b_r   [3];
    logic        cin_r [3];
    logic        iv_r  [3];

    logic [31:0] exp_sum   [3];
    logic        exp_cout  [3];
    logic        exp_valid [3];
    logic        exp_ovf   [3];
    logic        exp_zero  [3];

    logic [31:0] act_sum   [3];
    logic        act_cout  [3];
    logic        act_valid [3];
    logic        act_ovf   [3];
    logic        act_zero  [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk4(input string tag, input logic [3:0] s, input logic co, input logic v);
        chk({tag, " sum"}, 32'(bus4.sum), 32'(s));
        chk({tag, " c_out"}, 32'(bus4.c_out), 32'(co));
        chk({tag, " out_valid"}, 32'(bus4.out_valid), 32'(v));
    endtask

    task automatic drive4(input logic iv, input logic [3:0] a, input logic [3:0] b, input logic c);
        bus4.in_valid = iv;
        bus4.A        = a;
        bus4.B        = b;
        bus4.c_in     = c;
    endtask

    // Reference: plain integer arithmetic on w-bit operands.
    task automatic ref_add(input int w, input logic [31:0] a, input logic [31:0] b, input logic c,
                           output logic [31:0] s, output logic co, output logic ov, output logic z);
        longint mask;
        longint full;
        longint sa;
        longint sb;
        longint res;
        longint half;
        mask = (longint'(1) << w) - 64'sd1;
        half = longint'(1) << (w - 1);
        full = (longint'(a) & mask) + (longint'(b) & mask) + longint'(c);
        s    = 32'(full & mask);
        co   = ((full >> w) & 64'sd1) != 64'sd0;
        sa   = (longint'(a) & mask) >= half ? (longint'(a) & mask) - (mask + 64'sd1) : (longint'(a) & mask);
        sb   = (longint'(b) & mask) >= half ? (longint'(b) & mask) - (mask + 64'sd1) : (longint'(b) & mask);
        res  = sa + sb + longint'(c);
        ov   = (res > half - 64'sd1) || (res < -half);
        z    = (s == 32'd0);
    endtask

    task automatic gather();
        act_sum[0] = 32'(bus4.sum);  act_cout[0] = bus4.c_out;  act_valid[0] = bus4.out_valid;
        act_sum[1] = 32'(bus1.sum);  act_cout[1] = bus1.c_out;  act_valid[1] = bus1.out_valid;
        act_sum[2] = 32'(bus16.sum); act_cout[2] = bus16.c_out; act_valid[2] = bus16.out_valid;
`ifdef FULL_ADDER4_STATUS_EN
        act_ovf[0] = bus4.ovf;  act_zero[0] = bus4.zero;
        act_ovf[1] = bus1.ovf;  act_zero[1] = bus1.zero;
        act_ovf[2] = bus16.ovf; act_zero[2] = bus16.zero;
`else
        for (int d = 0; d < 3; d++) begin
            act_ovf[d]  = exp_ovf[d];
            act_zero[d] = exp_zero[d];
        end
`endif
    endtask

    initial begin
        logic [31:0] s_t;
        logic        co_t;
        logic        ov_t;
        logic        z_t;

        vecs[0] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{4'b0011, 4'b1010, 1'b0, 4'b1101, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{4'b0110, 4'b1011, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{4'b0101, 4'b1101, 1'b1, 4'b0011, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1};

        drive4(1'b0, 4'b0000, 4'b0000, 1'b0);
        bus1.in_valid  = 1'b0; bus1.A  = 1'b0;  bus1.B  = 1'b0;  bus1.c_in  = 1'b0;
        bus16.in_valid = 1'b0; bus16.A = 16'd0; bus16.B = 16'd0; bus16.c_in = 1'b0;

        // Reset state and one idle edge after release.
        #3;
        chk4("reset", 4'b0000, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk4("idle after release", 4'b0000, 1'b0, 1'b0);

        // Directed vector table, applied back to back.
        for (int i = 0; i < 7; i++) begin
            drive4(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin);
            tick();
            chk4($sformatf("vec%0d", i), vecs[i].exp_sum, vecs[i].exp_cout, 1'b1);
`ifdef FULL_ADDER4_STATUS_EN
            chk($sformatf("vec%0d ovf", i), 32'(bus4.ovf), 32'(vecs[i].exp_ovf));
            chk($sformatf("vec%0d zero", i), 32'(bus4.zero), 32'(vecs[i].exp_zero));
`endif
        end

        // Hold: result stays while in_valid is low, operands are garbage.
        drive4(1'b1, 4'b0101, 4'b1101, 1'b1);
        tick();
        chk4("hold load", 4'b0011, 1'b1, 1'b1);
        drive4(1'b0, 4'($urandom), 4'($urandom), 1'($urandom));
        tick();
        chk4("hold idle", 4'b0011, 1'b1, 1'b0);
        drive4(1'b0, 4'b1111, 4'b1111, 1'b1);
        tick();
        chk4("hold idle2", 4'b0011, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle, no clock edge in between.
        drive4(1'b1, 4'b0001, 4'b0001, 1'b0);
        tick();
        chk4("pre-async", 4'b0010, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk4("async rst", 4'b0000, 1'b0, 1'b0);
        // Pending capture under reset is discarded.
        drive4(1'b1, 4'b0101, 4'b0101, 1'b1);
        tick();
        chk4("edge in rst", 4'b0000, 1'b0, 1'b0);
        #2 rst = 1'b0;
        drive4(1'b0, 4'b0101, 4'b0101, 1'b1);
        tick();
        chk4("post rst idle", 4'b0000, 1'b0, 1'b0);
        // First valid edge after release captures.
        drive4(1'b1, 4'b0111, 4'b0111, 1'b1);
        tick();
        chk4("post rst load", 4'b1111, 1'b0, 1'b1);
`ifdef FULL_ADDER4_STATUS_EN
        chk("post rst load ovf", 32'(bus4.ovf), 32'd1);
`endif

        // Model state matching every instance now.
        exp_sum[0] = 32'hF; exp_cout[0] = 1'b0; exp_valid[0] = 1'b1; exp_ovf[0] = 1'b1; exp_zero[0] = 1'b0;
        for (int d = 1; d < 3; d++) begin
            exp_sum[d] = 32'd0; exp_cout[d] = 1'b0; exp_valid[d] = 1'b0; exp_ovf[d] = 1'b0; exp_zero[d] = 1'b0;
        end

        // Randomized back-to-back traffic on all widths.
        for (int i = 0; i < 1000; i++) begin
            for (int d = 0; d < 3; d++) begin
                a_r[d]   = $urandom;
                b_r[d]   = $urandom;
                cin_r[d] = 1'($urandom);
                iv_r[d]  = ($urandom_range(0, 3) != 0);
                if (i % 97 == 5) begin
                    a_r[d] = 32'hFFFF_FFFF; b_r[d] = 32'hFFFF_FFFF; cin_r[d] = 1'b1; iv_r[d] = 1'b1;
                end
                exp_valid[d] = iv_r[d];
                if (iv_r[d]) begin
                    ref_add(widths[d], a_r[d], b_r[d], cin_r[d], s_t, co_t, ov_t, z_t);
                    exp_sum[d] = s_t; exp_cout[d] = co_t; exp_ovf[d] = ov_t; exp_zero[d] = z_t;
                end
            end
            bus4.in_valid  = iv_r[0]; bus4.A  = a_r[0][3:0];  bus4.B  = b_r[0][3:0];  bus4.c_in  = cin_r[0];
            bus1.in_valid  = iv_r[1]; bus1.A  = a_r[1][0:0];  bus1.B  = b_r[1][0:0];  bus1.c_in  = cin_r[1];
            bus16.in_valid = iv_r[2]; bus16.A = a_r[2][15:0]; bus16.B = b_r[2][15:0]; bus16.c_in = cin_r[2];
            tick();
            gather();
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("rnd w%0d sum", widths[d]), act_sum[d], exp_sum[d]);
                chk($sformatf("rnd w%0d c_out", widths[d]), 32'(act_cout[d]), 32'(exp_cout[d]));
                chk($sformatf("rnd w%0d out_valid", widths[d]), 32'(act_valid[d]), 32'(exp_valid[d]));
`ifdef FULL_ADDER4_STATUS_EN
                chk($sformatf("rnd w%0d ovf", widths[d]), 32'(act_ovf[d]), 32'(exp_ovf[d]));
                chk($sformatf("rnd w%0d zero", widths[d]), 32'(act_zero[d]), 32'(exp_zero[d]));
`endif
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
